// File: rtl/muldiv_pkg.sv
// Shared types and operand-signedness helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} muldiv_state_t;

    function automatic logic is_signed_a(muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Start/done handshake bundle between the execute stage (master) and the multiply/divide unit (slave).
interface muldiv_if #(parameter int WIDTH = 32);
    import muldiv_pkg::*;

    logic             flush;
    logic             start;
    muldiv_op_t       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result;
    logic             Negative;
    logic             Zero;

    modport master (
        output flush, start, op, A, B,
        input  ready, busy, done, Result, Negative, Zero
    );

    modport slave (
        input  flush, start, op, A, B,
        output ready, busy, done, Result, Negative, Zero
    );

endinterface

// File: rtl/muldiv_core.sv
// Unsigned datapath: shift-add multiply or restoring divide, one bit per step.
// Multiply leaves the product in {acc_hi, acc_lo}; divide leaves remainder in acc_hi, quotient in acc_lo.
module muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             div_q, div_d;

    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   remShift;
    logic             remFits;
    logic [WIDTH-1:0] remSub;

    // The subtraction only matters when remShift >= divisor, so the result always fits WIDTH bits.
    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        div_d    = div_q;
        mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        remShift = {hi_q, lo_q[WIDTH-1]};
        remFits  = (remShift >= {1'b0, opnd_q});
        remSub   = remShift[WIDTH-1:0] - opnd_q;
        if (load) begin
            hi_d   = '0;
            lo_d   = a;
            opnd_d = b;
            div_d  = is_div;
        end else if (step) begin
            if (div_q) begin
                hi_d = remFits ? remSub : remShift[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], remFits};
            end else begin
                {hi_d, lo_d} = {mulSum, lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
            div_q  <= div_d;
        end
    end

    assign acc_hi = hi_q;
    assign acc_lo = lo_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: latches magnitudes, runs the unsigned core,
// then restores the sign in FIX. Division corner cases skip the core entirely.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    muldiv_state_t    state_q;
    logic [CNT_W-1:0] cnt_q;
    muldiv_op_t       op_q;
    logic             negRes_q;
    logic             special_q;
    logic [WIDTH-1:0] specRes_q;
    logic             ready_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             neg_q;
    logic             zero_q;

    logic             accept;
    logic             signA, signB;
    logic [WIDTH-1:0] absA, absB;
    logic             isDivOp, bZero, overflow, specialIn, negResIn;
    logic [WIDTH-1:0] specResIn;

    // Everything needed later is decided from the raw inputs on the accepting edge.
    always_comb begin
        accept    = bus.start & ready_q & ~bus.flush;
        signA     = is_signed_a(bus.op) & bus.A[WIDTH-1];
        signB     = is_signed_b(bus.op) & bus.B[WIDTH-1];
        absA      = signA ? -bus.A : bus.A;
        absB      = signB ? -bus.B : bus.B;
        isDivOp   = bus.op[2];
        bZero     = (bus.B == '0);
        overflow  = is_signed_b(bus.op) & isDivOp & (bus.A == MinNeg) & (bus.B == '1);
        specialIn = isDivOp & (bZero | overflow);
        negResIn  = (bus.op == OP_REM) ? signA : (signA ^ signB);
        specResIn = '0;
        if (bZero) begin
            specResIn = bus.op[1] ? bus.A : '1;
        end else if (overflow) begin
            specResIn = bus.op[1] ? '0 : MinNeg;
        end
    end

    logic [WIDTH-1:0] accHi, accLo;

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .step   (state_q == CALC),
        .is_div (isDivOp),
        .a      (absA),
        .b      (absB),
        .acc_hi (accHi),
        .acc_lo (accLo)
    );

    logic [2*WIDTH-1:0] product, productFix;
    logic [WIDTH-1:0]   quoFix, remFix, fixRes;

    always_comb begin
        product    = {accHi, accLo};
        productFix = negRes_q ? -product : product;
        quoFix     = negRes_q ? -accLo : accLo;
        remFix     = negRes_q ? -accHi : accHi;
        fixRes     = '0;
        if (special_q) begin
            fixRes = specRes_q;
        end else begin
            case (op_q)
                OP_MUL:                       fixRes = productFix[WIDTH-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU: fixRes = productFix[2*WIDTH-1:WIDTH];
                OP_DIV, OP_DIVU:              fixRes = quoFix;
                OP_REM, OP_REMU:              fixRes = remFix;
                default:                      fixRes = '0;
            endcase
        end
    end

    // Flush returns to IDLE but leaves the last Result and flags visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= OP_MUL;
            negRes_q  <= 1'b0;
            special_q <= 1'b0;
            specRes_q <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            result_q  <= '0;
            neg_q     <= 1'b0;
            zero_q    <= 1'b1;
        end else if (bus.flush) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        op_q      <= bus.op;
                        negRes_q  <= negResIn;
                        special_q <= specialIn;
                        specRes_q <= specResIn;
                        cnt_q     <= CNT_W'(WIDTH - 1);
                        ready_q   <= 1'b0;
                        state_q   <= specialIn ? FIX : CALC;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    result_q <= fixRes;
                    neg_q    <= fixRes[WIDTH-1];
                    zero_q   <= (fixRes == '0);
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.busy     = ~ready_q;
    assign bus.done     = done_q;
    assign bus.Result   = result_q;
    assign bus.Negative = neg_q;
    assign bus.Zero     = zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus queues expected results and accept cycles,
// a negedge monitor checks Result, flags and latency on every done pulse.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;
    localparam int NormLat = W + 2;
    localparam int SpecLat = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] res;
        int           acceptCyc;
        int           lat;
        string        name;
    } exp_t;

    exp_t         expQ[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [W-1:0] lastRes = '0;
    logic         prevDone = 1'b0;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.done) begin
            checkOutput("done_not_back_to_back", W'(prevDone), '0);
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1 with Result 0x%08h, expected no done", bus.Result);
            end else begin
                e = expQ.pop_front();
                checkOutput({e.name, "_result"}, bus.Result, e.res);
                checkOutput({e.name, "_negative"}, W'(bus.Negative), W'(e.res[W-1]));
                checkOutput({e.name, "_zero"}, W'(bus.Zero), W'(e.res == '0));
                checkOutput({e.name, "_latency"}, W'(cyc - e.acceptCyc + 1), W'(e.lat));
                lastRes = e.res;
            end
        end
        prevDone = bus.done;
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic applyStimulus(input muldiv_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] expRes, input int lat, input string name, input bit push);
        int waitCnt = 0;
        while (!bus.ready && waitCnt < 500) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!bus.ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_ready_timeout: ready=0, expected 1", name);
            return;
        end
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        if (push) expQ.push_back('{expRes, cyc + 1, lat, name});
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = ~a;
        bus.B     = ~b;
    endtask

    task automatic drain(input string name);
        int waitCnt = 0;
        while ((expQ.size() != 0 || !bus.ready) && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        if (expQ.size() != 0 || !bus.ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_drain_timeout: %0d results pending, expected 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    muldiv_op_t   tblOp[8]  = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    logic [W-1:0] tblRes[8] = '{32'hFFFFFFE8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000003,
                                32'hFFFFFFFF, 32'h3FFFFFFE, 32'hFFFFFFFE, 32'h00000002};

    initial begin
        logic [W-1:0] heldRes;
        int           accepted;
        int           lastAccept;
        int           guard;
        int           idx;

        reset     = 1'b1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        bus.op    = OP_MUL;
        bus.A     = '0;
        bus.B     = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_ready", W'(bus.ready), 1);
        checkOutput("reset_busy", W'(bus.busy), 0);
        checkOutput("reset_done", W'(bus.done), 0);
        checkOutput("reset_result", bus.Result, '0);
        checkOutput("reset_negative", W'(bus.Negative), 0);
        checkOutput("reset_zero", W'(bus.Zero), 1);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(OP_MUL,   32'd6,        32'd4,        32'h00000018, NormLat, "mul_6x4", 1);
        applyStimulus(OP_MULH,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, NormLat, "mulh_m1", 1);
        applyStimulus(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, NormLat, "mulhu_max", 1);
        applyStimulus(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, NormLat, "div_m7_2", 1);
        applyStimulus(OP_REM,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, NormLat, "rem_m7_2", 1);
        applyStimulus(OP_DIVU,  32'd7,        32'd2,        32'h00000003, NormLat, "divu_7_2", 1);
        applyStimulus(OP_DIV,   32'd5,        32'd0,        32'hFFFFFFFF, SpecLat, "div_by0", 1);
        applyStimulus(OP_REMU,  32'd5,        32'd0,        32'h00000005, SpecLat, "remu_by0", 1);
        applyStimulus(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, SpecLat, "div_ovf", 1);
        applyStimulus(OP_REM,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, SpecLat, "rem_ovf", 1);
        drain("directed");

        // Flush and start together: start must be dropped.
        bus.flush = 1'b1;
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.A     = 32'd3;
        bus.B     = 32'd3;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        checkOutput("flush_start_ready", W'(bus.ready), 1);
        repeat (3) @(negedge clk);

        // Flush part-way through a DIVU, then issue a MUL straight away.
        heldRes = lastRes;
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 32'd14, NormLat, "divu_flushed", 0);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        checkOutput("flush_ready", W'(bus.ready), 1);
        checkOutput("flush_done", W'(bus.done), 0);
        checkOutput("flush_result_held", bus.Result, heldRes);
        applyStimulus(OP_MUL, 32'h00001234, 32'h00000010, 32'h00012340, NormLat, "mul_after_flush", 1);
        drain("flush");

        // start held high; inputs change every cycle but only accepted ones matter.
        accepted   = 0;
        lastAccept = -1;
        guard      = 0;
        bus.start  = 1'b1;
        while (accepted < 5 && guard < 1000) begin
            if (bus.ready) begin
                idx    = int'($urandom_range(0, 7));
                bus.op = tblOp[idx];
                bus.A  = 32'hFFFFFFFA;
                bus.B  = 32'd4;
                expQ.push_back('{tblRes[idx], cyc + 1, NormLat, "stream"});
                if (lastAccept >= 0) checkOutput("stream_issue_gap", W'(cyc + 1 - lastAccept), W'(W + 3));
                lastAccept = cyc + 1;
                accepted++;
            end else begin
                bus.op = tblOp[$urandom_range(0, 7)];
                bus.A  = $urandom;
                bus.B  = $urandom;
            end
            @(negedge clk);
            guard++;
        end
        bus.start = 1'b0;
        if (accepted < 5) begin
            checks++;
            errors++;
            $display("[TB] FAIL stream_accepts: got %0d, expected 5", accepted);
        end
        drain("stream");

        // Reset in the middle of CALC: no done may follow.
        applyStimulus(OP_MUL, 32'd3, 32'd5, 32'd15, NormLat, "mul_reset", 0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst_ready", W'(bus.ready), 1);
        checkOutput("midrst_busy", W'(bus.busy), 0);
        checkOutput("midrst_done", W'(bus.done), 0);
        checkOutput("midrst_result", bus.Result, '0);
        checkOutput("midrst_negative", W'(bus.Negative), 0);
        checkOutput("midrst_zero", W'(bus.Zero), 1);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        applyStimulus(OP_MULHU, 32'h80000000, 32'd4, 32'h00000002, NormLat, "mulhu_after_rst", 1);
        drain("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
